// File: rtl/ccp_pkg.sv
// Shared constants and types for the CCP tag pipe and its tag-memory initialisation engine.
package ccp_pkg;

    localparam int ENTRY_W = 27;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        DONE     = 2'd2
    } init_state_e;

    // Index width for one bank's share of the sets; never narrower than one bit.
    function automatic int set_idx_width(input int n_sets, input int n_banks);
        int per_bank;
        per_bank = n_sets / n_banks;
        if (per_bank > 1) begin
            return $clog2(per_bank);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ccp_tag_init_engine.sv
// Sweeps every tag-memory set across all banks, writing invalid entries, after reset
// and on request; lookups are held off while init_busy is high.
module ccp_tag_init_engine
    import ccp_pkg::*;
#(
    parameter int  N_WAYS         = 4,
    parameter int  N_TAG_BANKS    = 2,
    parameter int  N_SETS         = 1024,
    parameter int  ENTRY_W        = ccp_pkg::ENTRY_W,
    localparam int SET_PER_BANK   = N_SETS / N_TAG_BANKS,
    localparam int SET_PER_BANK_W = set_idx_width(N_SETS, N_TAG_BANKS),
    localparam int WORD_W         = N_WAYS * ENTRY_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_req,
    input  logic [N_TAG_BANKS-1:0]    tag_wr_ready,
    output logic [N_TAG_BANKS-1:0]    tag_wr_valid,
    output logic [SET_PER_BANK_W-1:0] tag_wr_index,
    output logic [WORD_W-1:0]         tag_wr_data,
    output logic [N_WAYS-1:0]         tag_wr_way_mask,
    output logic                      init_busy,
    output logic                      init_done
);

    localparam logic [SET_PER_BANK_W-1:0] LAST_IDX = SET_PER_BANK_W'(SET_PER_BANK - 1);

    init_state_e               state_q, state_d;
    logic [SET_PER_BANK_W-1:0] idx_q, idx_d;
    logic [N_TAG_BANKS-1:0]    acc_q, acc_d;
    logic [N_TAG_BANKS-1:0]    valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [N_TAG_BANKS-1:0]    acc_now_s;

    // Banks finished at the current index, counting handshakes landing this cycle.
    assign acc_now_s = acc_q | (valid_q & tag_wr_ready);

    // State, index, tracker and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_WAIT;
            idx_q   <= {SET_PER_BANK_W{1'b0}};
            acc_q   <= {N_TAG_BANKS{1'b0}};
            valid_q <= {N_TAG_BANKS{1'b0}};
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, index advance and per-bank completion tracking.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            RST_WAIT: begin
                state_d = INIT;
            end
            INIT: begin
                if (&acc_now_s) begin
                    acc_d = {N_TAG_BANKS{1'b0}};
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = {SET_PER_BANK_W{1'b0}};
                    end else begin
                        idx_d = idx_q + SET_PER_BANK_W'(1);
                    end
                end else begin
                    acc_d = acc_now_s;
                end
            end
            DONE: begin
                if (init_req) begin
                    state_d = INIT;
                    idx_d   = {SET_PER_BANK_W{1'b0}};
                    acc_d   = {N_TAG_BANKS{1'b0}};
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = RST_WAIT;
                idx_d   = {SET_PER_BANK_W{1'b0}};
                acc_d   = {N_TAG_BANKS{1'b0}};
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        valid_d = {N_TAG_BANKS{1'b0}};
        if (state_d == INIT) begin
            valid_d = ~acc_d;
        end else begin
            valid_d = {N_TAG_BANKS{1'b0}};
        end
        busy_d = (state_d != DONE);
        done_d = (state_d == DONE);
    end

    assign tag_wr_valid    = valid_q;
    assign tag_wr_index    = idx_q;
    assign tag_wr_data     = {WORD_W{1'b0}};
    assign tag_wr_way_mask = {N_WAYS{1'b1}};
    assign init_busy       = busy_q;
    assign init_done       = done_q;

endmodule
